// File: rtl/bit2byte_strb_skid.sv
// bit2byte_strb_skid: converts a per-bit write mask into AXI byte strobes,
// zeroes unmasked data bits, flags partially masked bytes and counts them.
// A two-entry skid buffer (output reg + skid reg) keeps in_ready registered
// while sustaining one beat per clock under arbitrary backpressure.
//
// Ports:
//   ACLK, sysReset (async, active-low)
//   in_valid/in_ready, in_data, in_mask, in_last    : upstream beat
//   out_valid/out_ready, out_data, out_strb,
//   out_last, out_partial                           : downstream beat
//   partial_cnt, clr_cnt                            : saturating partial count
module bit2byte_strb_skid #(
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_POLICY = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    ACLK,
    input  logic                    sysReset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH-1:0]   in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_strb,
    output logic                    out_last,
    output logic                    out_partial,
    output logic [CNT_WIDTH-1:0]    partial_cnt,
    input  logic                    clr_cnt
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int ENT_W = DATA_WIDTH + NB + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ENT_W-1:0]     or_q, or_d;
    logic [ENT_W-1:0]     sr_q, sr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NB-1:0]        strb_c;
    logic                 part_c;
    logic [ENT_W-1:0]     in_ent;
    logic                 accept;

    // Byte-wise reduction of the bit mask.
    always_comb begin
        strb_c = '0;
        part_c = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (STRB_POLICY == 0) begin
                strb_c[k] = |in_mask[8*k +: 8];
            end else begin
                strb_c[k] = &in_mask[8*k +: 8];
            end
            part_c = part_c | ((|in_mask[8*k +: 8]) & ~(&in_mask[8*k +: 8]));
        end
    end

    // Entry layout: {partial, last, strb, data}
    assign in_ent = {part_c, in_last, strb_c, in_data & in_mask};
    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sr_d    = sr_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    or_d    = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    or_d = in_ent;
                end else if (accept) begin
                    sr_d    = in_ent;
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    or_d    = sr_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags are registered copies of the next occupancy.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (accept && part_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            state_q     <= EMPTY;
            or_q        <= '0;
            sr_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            or_q        <= or_d;
            sr_q        <= sr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = or_q[DATA_WIDTH-1:0];
    assign out_strb    = or_q[DATA_WIDTH +: NB];
    assign out_last    = or_q[DATA_WIDTH+NB];
    assign out_partial = or_q[DATA_WIDTH+NB+1];
    assign partial_cnt = cnt_q;

endmodule

// File: tb/tb_bit2byte_strb_skid.sv
// Bench for bit2byte_strb_skid: table vectors, stall/saturation/reset
// sequences and a randomized stream, all checked through a scoreboard queue.
module tb_bit2byte_strb_skid;

    logic        ACLK;
    logic        sysReset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_mask;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;
    logic        out_partial;
    logic [3:0]  partial_cnt;
    logic        clr_cnt;

    logic        in_ready1;
    logic        out_valid1;
    logic [31:0] out_data1;
    logic [3:0]  out_strb1;
    logic        out_last1;
    logic        out_partial1;
    logic [3:0]  partial_cnt1;

    bit2byte_strb_skid #(
        .DATA_WIDTH(32), .STRB_POLICY(0), .CNT_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .sysReset(sysReset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_strb(out_strb),
        .out_last(out_last), .out_partial(out_partial),
        .partial_cnt(partial_cnt), .clr_cnt(clr_cnt)
    );

    bit2byte_strb_skid #(
        .DATA_WIDTH(32), .STRB_POLICY(1), .CNT_WIDTH(4)
    ) dut1 (
        .ACLK(ACLK), .sysReset(sysReset),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_strb(out_strb1),
        .out_last(out_last1), .out_partial(out_partial1),
        .partial_cnt(partial_cnt1), .clr_cnt(clr_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb0;
        logic [3:0]  strb1;
        logic        last;
        logic        partial;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        logic        l;
        exp_t        e;
    } vec_t;

    exp_t        sbq[$];
    int          checks;
    int          errors;
    int          mcnt;
    bit          hold;
    logic [37:0] held;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] d,
                                   input logic [31:0] m,
                                   input logic l);
        exp_t   e;
        logic [7:0] b;
        e.data    = d & m;
        e.strb0   = '0;
        e.strb1   = '0;
        e.last    = l;
        e.partial = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b = m[8*k +: 8];
            e.strb0[k] = |b;
            e.strb1[k] = &b;
            if ((|b) && !(&b)) e.partial = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive at posedge+1, check and update model at negedge.
    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic [31:0] m, input logic l,
                         input logic r, input logic c,
                         input exp_t e, output logic acc);
        exp_t f;
        in_valid  = v;
        in_data   = d;
        in_mask   = m;
        in_last   = l;
        out_ready = r;
        clr_cnt   = c;
        @(negedge ACLK);
        chk("in_ready", {63'd0, in_ready}, (sbq.size() < 2) ? 64'd1 : 64'd0);
        chk("out_valid", {63'd0, out_valid}, (sbq.size() != 0) ? 64'd1 : 64'd0);
        chk("partial_cnt", {60'd0, partial_cnt}, 64'(mcnt));
        if (hold) begin
            chk("stable", {26'd0, out_data, out_strb, out_last, out_partial},
                {26'd0, held});
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                f = sbq.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, f.data});
                chk("out_strb", {60'd0, out_strb}, {60'd0, f.strb0});
                chk("out_strb_p1", {60'd0, out_strb1}, {60'd0, f.strb1});
                chk("out_last", {63'd0, out_last}, {63'd0, f.last});
                chk("out_partial", {63'd0, out_partial}, {63'd0, f.partial});
            end
        end
        acc = v && in_ready;
        if (acc) sbq.push_back(e);
        if (c) begin
            mcnt = 0;
        end else if (acc && e.partial && mcnt < 15) begin
            mcnt++;
        end
        hold = out_valid && !out_ready;
        held = {out_data, out_strb, out_last, out_partial};
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle(input logic r);
        logic a;
        exp_t z;
        z = model(32'd0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, r, 1'b0, z, a);
    endtask

    vec_t   vt[6];
    logic   a;
    int     n;
    int     acc_n;
    int     cyc;
    logic [31:0] d;
    logic [31:0] m;
    logic   v;
    logic   r;
    logic   c;
    logic   l;
    logic [7:0] pat;

    initial begin
        checks = 0;
        errors = 0;
        mcnt   = 0;
        hold   = 1'b0;
        held   = '0;
        sysReset  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;

        vt[0] = '{32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0,
                  '{32'hA5A5A5A5, 4'hF, 4'hF, 1'b0, 1'b0}};
        vt[1] = '{32'hFFFFFFFF, 32'h00FF0F00, 1'b0,
                  '{32'h00FF0F00, 4'b0110, 4'b0100, 1'b0, 1'b1}};
        vt[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0,
                  '{32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0}};
        vt[3] = '{32'h12345678, 32'h80000001, 1'b1,
                  '{32'h00000000, 4'b1001, 4'b0000, 1'b1, 1'b1}};
        vt[4] = '{32'hDEADBEEF, 32'hFF00FF00, 1'b0,
                  '{32'hDE00BE00, 4'b1010, 4'b1010, 1'b0, 1'b0}};
        vt[5] = '{32'hCAFEF00D, 32'h0000FFF0, 1'b1,
                  '{32'h0000F000, 4'b0011, 4'b0010, 1'b1, 1'b1}};

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_strb", {60'd0, out_strb}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_partial", {63'd0, out_partial}, 64'd0);
        chk("rst_cnt", {60'd0, partial_cnt}, 64'd0);
        @(negedge ACLK);
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;

        // Table vectors, back to back with out_ready high.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vt[i].d, vt[i].m, vt[i].l, 1'b1, 1'b0, vt[i].e, a);
            chk("tbl_accept", {63'd0, a}, 64'd1);
            chk("tbl_latency", {63'd0, out_valid}, 64'd1);
        end
        chk("tbl_cnt", {60'd0, partial_cnt}, 64'd3);
        idle(1'b1);
        idle(1'b1);

        // 8-beat stream against a fixed backpressure pattern.
        pat = 8'b1110_1001;
        n = 0;
        cyc = 0;
        while ((n < 8 || sbq.size() != 0) && cyc < 50) begin
            r = (cyc < 8) ? pat[cyc] : 1'b1;
            if (n < 8) begin
                d = 32'h1000_0000 + 32'(n);
                cycle(1'b1, d, 32'hFFFFFFFF, (n == 7), r, 1'b0,
                      model(d, 32'hFFFFFFFF, (n == 7)), a);
                if (a) n++;
            end else begin
                idle(r);
            end
            if (cyc == 0) chk("stall_rdy0", {63'd0, in_ready}, 64'd1);
            if (cyc == 1) chk("stall_rdy1", {63'd0, in_ready}, 64'd0);
            cyc++;
        end
        chk("stream_done", 64'(n), 64'd8);
        chk("stream_drain", 64'(sbq.size()), 64'd0);

        // Counter saturation and clear priority.
        d = 32'hFFFFFFFF;
        m = 32'h0000000F;
        idle(1'b1);
        cycle(1'b0, d, m, 1'b0, 1'b1, 1'b1, model(d, m, 1'b0), a);
        chk("cnt_clr", {60'd0, partial_cnt}, 64'd0);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, d, m, 1'b0, 1'b1, 1'b0, model(d, m, 1'b0), a);
        end
        chk("cnt_max_m1", {60'd0, partial_cnt}, 64'd14);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, d, m, 1'b0, 1'b1, 1'b0, model(d, m, 1'b0), a);
        end
        chk("cnt_sat", {60'd0, partial_cnt}, 64'd15);
        cycle(1'b1, d, m, 1'b0, 1'b1, 1'b1, model(d, m, 1'b0), a);
        chk("cnt_clr_prio", {60'd0, partial_cnt}, 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Fill both entries, then reset asynchronously mid-cycle.
        cycle(1'b1, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
              model(32'h1111_1111, 32'hFFFF_FFFF, 1'b0), a);
        cycle(1'b1, 32'h2222_2222, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0,
              model(32'h2222_2222, 32'h0FFF_FFFF, 1'b0), a);
        chk("full_rdy", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        #2;
        sysReset = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_cnt", {60'd0, partial_cnt}, 64'd0);
        sbq.delete();
        mcnt = 0;
        hold = 1'b0;
        @(negedge ACLK);
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;
        cycle(1'b1, 32'h3333_3333, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
              model(32'h3333_3333, 32'hFFFF_FFFF, 1'b1), a);
        idle(1'b1);
        chk("arst_drain", 64'(sbq.size()), 64'd0);

        // Randomized stream.
        acc_n = 0;
        cyc = 0;
        while (acc_n < 10000 && cyc < 40000) begin
            d = $urandom;
            m = $urandom;
            if ($urandom_range(2) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    m[8*k +: 8] = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
                end
            end
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(9) < 7);
            c = ($urandom_range(63) == 0);
            l = ($urandom_range(7) == 0);
            cycle(v, d, m, l, r, c, model(d, m, l), a);
            if (a) acc_n++;
            cyc++;
        end
        chk("rand_beats", 64'(acc_n), 64'd10000);
        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            idle(1'b1);
            n++;
        end
        chk("rand_drain", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
